// File: rtl/cayde_wb_arbiter.sv
// Round-robin writeback arbiter sharing one register-file write port among
// NUM_REQ producers, with a 32-entry pending-write scoreboard and sticky error.
module cayde_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int AW      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  input  logic [NUM_REQ*AW-1:0]   req_addr_in,
  input  logic [NUM_REQ*XLEN-1:0] req_data_in,
  input  logic                    alloc_valid_in,
  input  logic [AW-1:0]           alloc_addr_in,
  output logic [31:0]             busy_out,
  output logic                    rf_wen_out,
  output logic [AW-1:0]           rf_waddr_out,
  output logic [XLEN-1:0]         rf_wdata_out,
  output logic                    wb_err_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: requester i transfers at a posedge where req_valid_in[i] &
  // req_ready_out[i]; ready is a pure function of valid and the pointer, and
  // a requester holds valid/addr/data stable until that edge.

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      idx;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [AW-1:0]      acc_addr;
  logic [XLEN-1:0]    acc_data;

  logic               wen_q, wen_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [31:0]        busy_q, busy_d;
  logic [31:0]        set_vec, clr_vec;
  logic               alloc_hit;
  logic               err_q, err_d;

  always_comb begin : arbitrate
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    accept  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!accept && req_valid_in[idx]) begin
        accept       = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  assign req_ready_out = grant;
  assign acc_addr      = req_addr_in[gnt_idx*AW +: AW];
  assign acc_data      = req_data_in[gnt_idx*XLEN +: XLEN];

  always_comb begin : next_state
    ptr_d   = ptr_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept) begin
      ptr_d   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      wen_d   = (acc_addr != '0);
      waddr_d = acc_addr;
      wdata_d = acc_data;
    end
  end

  // A same-cycle allocation of the written register wins over the clear: a
  // newer producer is now outstanding for it.
  always_comb begin : scoreboard
    set_vec = '0;
    clr_vec = '0;
    for (int r = 1; r < 32; r++) begin
      set_vec[r] = alloc_valid_in && (alloc_addr_in == AW'(r));
      clr_vec[r] = accept && (acc_addr == AW'(r));
    end
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
    alloc_hit = alloc_valid_in && (alloc_addr_in == acc_addr);
    err_d     = err_q | (accept && (acc_addr != '0) && !busy_q[acc_addr] && !alloc_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign rf_wen_out   = wen_q;
  assign rf_waddr_out = waddr_q;
  assign rf_wdata_out = wdata_q;
  assign busy_out     = busy_q;
  assign wb_err_out   = err_q;

endmodule

// File: tb/tb_cayde_wb_arbiter.sv
// Self-checking bench for cayde_wb_arbiter: a reference model predicts grants,
// register-file writes (queued), scoreboard bits and the sticky error.
module tb_cayde_wb_arbiter;

  localparam int NR = 3;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int W  = 1 + AW + XL;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid_in;
  logic [NR-1:0]     req_ready_out;
  logic [NR*AW-1:0]  req_addr_in;
  logic [NR*XL-1:0]  req_data_in;
  logic              alloc_valid_in;
  logic [AW-1:0]     alloc_addr_in;
  logic [31:0]       busy_out;
  logic              rf_wen_out;
  logic [AW-1:0]     rf_waddr_out;
  logic [XL-1:0]     rf_wdata_out;
  logic              wb_err_out;

  cayde_wb_arbiter #(.NUM_REQ(NR), .XLEN(XL), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_addr_in    (req_addr_in),
    .req_data_in    (req_data_in),
    .alloc_valid_in (alloc_valid_in),
    .alloc_addr_in  (alloc_addr_in),
    .busy_out       (busy_out),
    .rf_wen_out     (rf_wen_out),
    .rf_waddr_out   (rf_waddr_out),
    .rf_wdata_out   (rf_wdata_out),
    .wb_err_out     (wb_err_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  int              vectors = 0;
  int              errors  = 0;
  logic [W-1:0]    exp_q[$];
  int              m_ptr;
  int              m_gnt;
  logic [31:0]     m_busy;
  logic            m_err;
  logic [AW-1:0]   m_last_addr;
  logic [XL-1:0]   m_last_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr       = 0;
    m_gnt       = -1;
    m_busy      = '0;
    m_err       = 1'b0;
    m_last_addr = '0;
    m_last_data = '0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    req_valid_in   = '0;
    req_addr_in    = '0;
    req_data_in    = '0;
    alloc_valid_in = 1'b0;
    alloc_addr_in  = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XL-1:0] d);
    req_valid_in[i]        = 1'b1;
    req_addr_in[i*AW +: AW] = a;
    req_data_in[i*XL +: XL] = d;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wen"},   64'(rf_wen_out),   64'd0);
    check({tag, "_waddr"}, 64'(rf_waddr_out), 64'd0);
    check({tag, "_wdata"}, 64'(rf_wdata_out), 64'd0);
    check({tag, "_busy"},  64'(busy_out),     64'd0);
    check({tag, "_err"},   64'(wb_err_out),   64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset");
    model_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: called near the negedge with inputs set; returns at next negedge.
  task automatic step(input string tag);
    logic [2*NR-1:0] dbl;
    logic [NR-1:0]   exp_ready;
    logic [AW-1:0]   a;
    logic [XL-1:0]   d;
    logic [W-1:0]    w;
    #1;
    dbl   = {req_valid_in, req_valid_in} >> m_ptr;
    m_gnt = -1;
    for (int j = NR - 1; j >= 0; j--)
      if (dbl[j]) m_gnt = (m_ptr + j) % NR;
    exp_ready = '0;
    if (m_gnt >= 0) exp_ready[m_gnt] = 1'b1;
    check({tag, "_ready"}, 64'(req_ready_out), 64'(exp_ready));
    if (m_gnt >= 0) begin
      a = req_addr_in[m_gnt*AW +: AW];
      d = req_data_in[m_gnt*XL +: XL];
      exp_q.push_back({a != '0, a, d});
      if (a != '0 && !m_busy[a] && !(alloc_valid_in && alloc_addr_in == a)) m_err = 1'b1;
      if (a != '0) m_busy[a] = 1'b0;
      m_last_addr = a;
      m_last_data = d;
      m_ptr       = (m_gnt + 1) % NR;
    end else begin
      exp_q.push_back({1'b0, m_last_addr, m_last_data});
    end
    if (alloc_valid_in && alloc_addr_in != '0) m_busy[alloc_addr_in] = 1'b1;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      w = exp_q.pop_front();
      check({tag, "_wen"},   64'(rf_wen_out),   64'(w[W-1]));
      check({tag, "_waddr"}, 64'(rf_waddr_out), 64'(w[XL +: AW]));
      check({tag, "_wdata"}, 64'(rf_wdata_out), 64'(w[XL-1:0]));
    end
    check({tag, "_busy"}, 64'(busy_out),   64'(m_busy));
    check({tag, "_err"},  64'(wb_err_out), 64'(m_err));
    @(negedge clk);
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    alloc_valid_in = 1'b1;
    alloc_addr_in  = a;
    step("alloc");
    alloc_valid_in = 1'b0;
  endtask

  // Run until every raised requester has been accepted, dropping each winner.
  task automatic drain(input string tag);
    int budget = 20;
    while (req_valid_in != '0 && budget > 0) begin
      step(tag);
      if (m_gnt >= 0) req_valid_in[m_gnt] = 1'b0;
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();
    @(negedge clk);

    // 1: single ALU writeback to an allocated register
    alloc(5'd5);
    check("t1_busy5_set", 64'(busy_out[5]), 64'd1);
    set_req(0, 5'd5, 32'hDEADBEEF);
    drain("t1");
    check("t1_busy5_clr", 64'(busy_out[5]), 64'd0);
    step("t1_idle");

    // 2: all three valid from pointer 0
    do_reset();
    alloc(5'd1); alloc(5'd2); alloc(5'd3);
    set_req(0, 5'd1, 32'h1111_0001);
    set_req(1, 5'd2, 32'h2222_0002);
    set_req(2, 5'd3, 32'h3333_0003);
    drain("t2");
    step("t2_idle");

    // 3: move pointer to 2 via requester 1, then 101 wraps 2 -> 0
    alloc(5'd4);
    set_req(1, 5'd4, 32'h4444_0004);
    drain("t3_pre");
    alloc(5'd10); alloc(5'd11);
    set_req(0, 5'd10, 32'hA0A0_000A);
    set_req(2, 5'd11, 32'hB0B0_000B);
    drain("t3");

    // 4: load unit writes x0
    set_req(1, 5'd0, 32'h0000_1234);
    drain("t4");
    step("t4_idle");

    // 5: allocation and writeback of x7 in the same cycle
    alloc(5'd7);
    alloc_valid_in = 1'b1;
    alloc_addr_in  = 5'd7;
    set_req(0, 5'd7, 32'h7777_0001);
    drain("t5_same");
    alloc_valid_in = 1'b0;
    check("t5_busy7_held", 64'(busy_out[7]), 64'd1);
    set_req(0, 5'd7, 32'h7777_0002);
    drain("t5_clear");
    check("t5_busy7_clr", 64'(busy_out[7]), 64'd0);

    // Random mix of requests and allocations
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid_in[i] && $urandom_range(0, 1) == 1)
          set_req(i, AW'($urandom_range(0, 31)), $urandom);
      alloc_valid_in = ($urandom_range(0, 2) == 0);
      alloc_addr_in  = AW'($urandom_range(0, 31));
      step("rnd");
      if (m_gnt >= 0) req_valid_in[m_gnt] = 1'b0;
    end
    idle_inputs();
    step("rnd_idle");

    // 6: write to non-allocated x9, sticky error, then async reset mid-stream
    do_reset();
    set_req(2, 5'd9, 32'h9999_0009);
    drain("t6");
    check("t6_err_set", 64'(wb_err_out), 64'd1);
    step("t6_sticky");
    set_req(0, 5'd12, 32'hCCCC_000C);
    drain("t6_err_hold");
    check("t6_wen_before_rst", 64'(rf_wen_out), 64'd1);
    #2;
    do_reset();
    set_req(0, 5'd13, 32'hD0D0_000D);
    set_req(1, 5'd14, 32'hE0E0_000E);
    step("t6_ptr0");
    check("t6_first_grant", 64'(m_gnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
